// File: rtl/footsies_pkg.sv
// footsies_pkg
// Shared definitions for the fighting-game datapath: hit arbiter state
// encoding, winner codes, the sprite state encoding used by the player FSM
// and Sprite_Hitbox, sprite/hitbox dimensions, and a saturating score helper.
// No ports; imported with "import footsies_pkg::*;".
package footsies_pkg;

    // Hit arbiter states
    typedef enum logic [1:0] {
        ST_FIGHT      = 2'd0,
        ST_HITSTOP    = 2'd1,
        ST_ROUND_OVER = 2'd2
    } arb_state_t;

    // Winner codes; bit 0 = P1 reached the win score, bit 1 = P2 did
    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;
    localparam logic [1:0] WINNER_DRAW = 2'd3;

    // Sprite states shared with the player FSM and Sprite_Hitbox
    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        WALK_FWD         = 3'd1,
        WALK_BACK        = 3'd2,
        ATTACK_STARTUP   = 3'd3,
        ATTACK_ACTIVE    = 3'd4,
        ATTACK_RECOVERY  = 3'd5
    } sprite_state_t;

    // Sprite and hitbox dimensions in pixels
    localparam int SPRITE_W    = 64;
    localparam int SPRITE_H    = 128;
    localparam int HURT_MARGIN = 10;
    localparam int HIT_W       = 30;
    localparam int HIT_H       = 60;

    // Score increment that sticks at 15 instead of wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'd15) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// box_overlap
// Combinational axis-aligned box intersection test using half-open
// intervals, so boxes that only share an edge do not overlap.
// Ports:
//   a_x1, a_x2, a_y1, a_y2 : first box corners (unsigned)
//   b_x1, b_x2, b_y1, b_y2 : second box corners (unsigned)
//   overlap                : 1 when the interiors intersect
module box_overlap #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] a_x1,
    input  logic [COORD_W-1:0] a_x2,
    input  logic [COORD_W-1:0] a_y1,
    input  logic [COORD_W-1:0] a_y2,
    input  logic [COORD_W-1:0] b_x1,
    input  logic [COORD_W-1:0] b_x2,
    input  logic [COORD_W-1:0] b_y1,
    input  logic [COORD_W-1:0] b_y2,
    output logic               overlap
);

    assign overlap = (a_x1 < b_x2) && (b_x1 < a_x2) &&
                     (a_y1 < b_y2) && (b_y1 < a_y2);

endmodule

// File: rtl/hit_arbiter.sv
// hit_arbiter
// Once per frame, tests each player's hitbox against the opponent's hurtbox,
// registers at most one hit per attack-active window, runs the hitstop
// freeze and keeps the round score. All outputs are registered.
// Optional feature macro: TRADE_EN (simultaneous strikes become a trade
// instead of a clash).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   frame_tick          : one-cycle frame pulse; all evaluation happens on it
//   restart             : level, leaves ROUND_OVER
//   p1_hit_*, p1_hurt_* : P1 hitbox / hurtbox corners and valid flags
//   p2_hit_*, p2_hurt_* : P2 hitbox / hurtbox corners and valid flags
//   p1_got_hit          : one-cycle pulse, P1 was struck
//   p2_got_hit          : one-cycle pulse, P2 was struck
//   freeze              : high in HITSTOP and ROUND_OVER
//   p1_score, p2_score  : current points (saturate at 15)
//   round_over          : high in ROUND_OVER
//   winner              : 0 none, 1 P1, 2 P2, 3 draw
module hit_arbiter
    import footsies_pkg::*;
#(
    parameter int COORD_W        = 10,
    parameter int HITSTOP_FRAMES = 8,
    parameter int WIN_SCORE      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic [COORD_W-1:0] p1_hit_x1,
    input  logic [COORD_W-1:0] p1_hit_x2,
    input  logic [COORD_W-1:0] p1_hit_y1,
    input  logic [COORD_W-1:0] p1_hit_y2,
    input  logic               p1_hit_active,
    input  logic [COORD_W-1:0] p1_hurt_x1,
    input  logic [COORD_W-1:0] p1_hurt_x2,
    input  logic [COORD_W-1:0] p1_hurt_y1,
    input  logic [COORD_W-1:0] p1_hurt_y2,
    input  logic               p1_hurt_active,
    input  logic [COORD_W-1:0] p2_hit_x1,
    input  logic [COORD_W-1:0] p2_hit_x2,
    input  logic [COORD_W-1:0] p2_hit_y1,
    input  logic [COORD_W-1:0] p2_hit_y2,
    input  logic               p2_hit_active,
    input  logic [COORD_W-1:0] p2_hurt_x1,
    input  logic [COORD_W-1:0] p2_hurt_x2,
    input  logic [COORD_W-1:0] p2_hurt_y1,
    input  logic [COORD_W-1:0] p2_hurt_y2,
    input  logic               p2_hurt_active,
    output logic               p1_got_hit,
    output logic               p2_got_hit,
    output logic               freeze,
    output logic [3:0]         p1_score,
    output logic [3:0]         p2_score,
    output logic               round_over,
    output logic [1:0]         winner
);

    localparam logic [7:0] HITSTOP_LOAD = 8'(HITSTOP_FRAMES);
    localparam logic [3:0] WIN_LIMIT    = 4'(WIN_SCORE);

    arb_state_t state;
    logic [7:0] hitstop_cnt;
    logic       p1_consumed;
    logic       p2_consumed;
    logic       p1_overlap;
    logic       p2_overlap;
    logic       p1_strike;
    logic       p2_strike;
    logic       p1_wins;
    logic       p2_wins;

    box_overlap #(.COORD_W(COORD_W)) u_p1_on_p2 (
        .a_x1(p1_hit_x1),  .a_x2(p1_hit_x2),  .a_y1(p1_hit_y1),  .a_y2(p1_hit_y2),
        .b_x1(p2_hurt_x1), .b_x2(p2_hurt_x2), .b_y1(p2_hurt_y1), .b_y2(p2_hurt_y2),
        .overlap(p1_overlap)
    );

    box_overlap #(.COORD_W(COORD_W)) u_p2_on_p1 (
        .a_x1(p2_hit_x1),  .a_x2(p2_hit_x2),  .a_y1(p2_hit_y1),  .a_y2(p2_hit_y2),
        .b_x1(p1_hurt_x1), .b_x2(p1_hurt_x2), .b_y1(p1_hurt_y1), .b_y2(p1_hurt_y2),
        .overlap(p2_overlap)
    );

    // A consumed attacker cannot strike again until its hitbox drops
    assign p1_strike = p1_hit_active & p2_hurt_active & p1_overlap & ~p1_consumed;
    assign p2_strike = p2_hit_active & p1_hurt_active & p2_overlap & ~p2_consumed;

    assign p1_wins = (p1_score >= WIN_LIMIT);
    assign p2_wins = (p2_score >= WIN_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FIGHT;
            hitstop_cnt <= 8'd0;
            p1_consumed <= 1'b0;
            p2_consumed <= 1'b0;
            p1_got_hit  <= 1'b0;
            p2_got_hit  <= 1'b0;
            freeze      <= 1'b0;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            round_over  <= 1'b0;
            winner      <= WINNER_NONE;
        end else begin
            p1_got_hit <= 1'b0;
            p2_got_hit <= 1'b0;

            if (frame_tick) begin
                // Dropping the hitbox on a frame ends its active window
                if (!p1_hit_active) p1_consumed <= 1'b0;
                if (!p2_hit_active) p2_consumed <= 1'b0;

                unique case (state)
                    ST_FIGHT: begin
                        if (p1_strike && p2_strike) begin
                            p1_consumed <= 1'b1;
                            p2_consumed <= 1'b1;
`ifdef TRADE_EN
                            p1_got_hit  <= 1'b1;
                            p2_got_hit  <= 1'b1;
                            p1_score    <= sat_inc(p1_score);
                            p2_score    <= sat_inc(p2_score);
                            hitstop_cnt <= HITSTOP_LOAD;
                            freeze      <= 1'b1;
                            state       <= ST_HITSTOP;
`endif
                        end else if (p1_strike) begin
                            p1_consumed <= 1'b1;
                            p2_got_hit  <= 1'b1;
                            p1_score    <= sat_inc(p1_score);
                            hitstop_cnt <= HITSTOP_LOAD;
                            freeze      <= 1'b1;
                            state       <= ST_HITSTOP;
                        end else if (p2_strike) begin
                            p2_consumed <= 1'b1;
                            p1_got_hit  <= 1'b1;
                            p2_score    <= sat_inc(p2_score);
                            hitstop_cnt <= HITSTOP_LOAD;
                            freeze      <= 1'b1;
                            state       <= ST_HITSTOP;
                        end
                    end

                    ST_HITSTOP: begin
                        // The tick that empties the counter also leaves
                        // HITSTOP, so freeze spans exactly HITSTOP_FRAMES ticks
                        if (hitstop_cnt <= 8'd1) begin
                            hitstop_cnt <= 8'd0;
                            if (p1_wins || p2_wins) begin
                                state      <= ST_ROUND_OVER;
                                round_over <= 1'b1;
                                winner     <= {p2_wins, p1_wins};
                            end else begin
                                state  <= ST_FIGHT;
                                freeze <= 1'b0;
                            end
                        end else begin
                            hitstop_cnt <= hitstop_cnt - 8'd1;
                        end
                    end

                    ST_ROUND_OVER: begin
                    end

                    default: begin
                        state <= ST_FIGHT;
                    end
                endcase
            end

            // Restart does not wait for a frame tick
            if (state == ST_ROUND_OVER && restart) begin
                state       <= ST_FIGHT;
                hitstop_cnt <= 8'd0;
                p1_consumed <= 1'b0;
                p2_consumed <= 1'b0;
                freeze      <= 1'b0;
                p1_score    <= 4'd0;
                p2_score    <= 4'd0;
                round_over  <= 1'b0;
                winner      <= WINNER_NONE;
            end
        end
    end

endmodule

// File: tb/tb_hit_arbiter.sv
// tb_hit_arbiter
// Scoreboard bench for hit_arbiter: each expected got_hit event is queued
// when the stimulus is issued and a monitor pops and compares it when the
// DUT pulses. Level outputs are checked directly against hand-computed
// values. Honors TRADE_EN to match the RTL build.
module tb_hit_arbiter;

    localparam int CW = 10;

    typedef struct packed {
        logic       p1_hit;
        logic       p2_hit;
        logic [3:0] s1;
        logic [3:0] s2;
    } event_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          restart = 1'b0;
    logic [CW-1:0] p1_hit_x1 = '0, p1_hit_x2 = '0, p1_hit_y1 = '0, p1_hit_y2 = '0;
    logic          p1_hit_active = 1'b0;
    logic [CW-1:0] p1_hurt_x1 = '0, p1_hurt_x2 = '0, p1_hurt_y1 = '0, p1_hurt_y2 = '0;
    logic          p1_hurt_active = 1'b0;
    logic [CW-1:0] p2_hit_x1 = '0, p2_hit_x2 = '0, p2_hit_y1 = '0, p2_hit_y2 = '0;
    logic          p2_hit_active = 1'b0;
    logic [CW-1:0] p2_hurt_x1 = '0, p2_hurt_x2 = '0, p2_hurt_y1 = '0, p2_hurt_y2 = '0;
    logic          p2_hurt_active = 1'b0;
    logic          p1_got_hit, p2_got_hit, freeze, round_over;
    logic [3:0]    p1_score, p2_score;
    logic [1:0]    winner;

    int compared   = 0;
    int mismatched = 0;
    event_t exp_q[$];

    always #5 clk = ~clk;

    hit_arbiter #(.COORD_W(CW), .HITSTOP_FRAMES(8), .WIN_SCORE(3)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p1_hit_active(p1_hit_active),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p1_hurt_active(p1_hurt_active),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p2_hit_active(p2_hit_active),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p2_hurt_active(p2_hurt_active),
        .p1_got_hit(p1_got_hit), .p2_got_hit(p2_got_hit), .freeze(freeze),
        .p1_score(p1_score), .p2_score(p2_score), .round_over(round_over), .winner(winner)
    );

    // Monitor: every got_hit pulse must match the oldest queued event
    always @(negedge clk) begin
        event_t got;
        event_t want;
        if (!rst && (p1_got_hit || p2_got_hit)) begin
            got = '{p1_got_hit, p2_got_hit, p1_score, p2_score};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_hit: got %b, required no pulse", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    mismatched++;
                    $display("[TB] FAIL hit_event: got p1=%b p2=%b s1=%0d s2=%0d, required p1=%b p2=%b s1=%0d s2=%0d",
                             got.p1_hit, got.p2_hit, got.s1, got.s2,
                             want.p1_hit, want.p2_hit, want.s1, want.s2);
                end
            end
        end
    end

    // One frame: tick for one cycle, then idle one cycle before the next
    task automatic applyStimulus(input int frames);
        for (int i = 0; i < frames; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic expectHit(input logic h1, input logic h2, input int s1, input int s2);
        exp_q.push_back('{h1, h2, 4'(s1), 4'(s2)});
    endtask

    // Drop P1's hitbox for one tick to open a fresh active window
    task automatic reopenP1();
        p1_hit_active = 1'b0;
        applyStimulus(1);
        p1_hit_active = 1'b1;
    endtask

    initial begin
        // Boxes: P1 hit overlaps P2 hurt; P2 hit overlaps P1 hurt
        p1_hit_x1 = 150; p1_hit_x2 = 180; p1_hit_y1 = 174; p1_hit_y2 = 234;
        p2_hurt_x1 = 160; p2_hurt_x2 = 214; p2_hurt_y1 = 110; p2_hurt_y2 = 238;
        p1_hurt_x1 = 100; p1_hurt_x2 = 164; p1_hurt_y1 = 110; p1_hurt_y2 = 238;
        p2_hit_x1 = 140; p2_hit_x2 = 170; p2_hit_y1 = 174; p2_hit_y2 = 234;
        p1_hurt_active = 1'b1;
        p2_hurt_active = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_freeze", freeze, 0);
        checkOutput("reset_score", {p1_score, p2_score}, 0);
        checkOutput("reset_round_over", round_over, 0);
        checkOutput("reset_winner", winner, 0);

        $display("[TB] single hit and hitstop");
        p1_hit_active = 1'b1;
        expectHit(1'b0, 1'b1, 1, 0);
        applyStimulus(1);
        checkOutput("hitstop_freeze_start", freeze, 1);
        applyStimulus(7);
        checkOutput("hitstop_freeze_tick7", freeze, 1);
        applyStimulus(1);
        checkOutput("hitstop_freeze_end", freeze, 0);

        $display("[TB] persistent overlap gives one hit per window");
        applyStimulus(3);
        checkOutput("persist_score", p1_score, 1);
        reopenP1();
        expectHit(1'b0, 1'b1, 2, 0);
        applyStimulus(1);
        applyStimulus(8);
        checkOutput("second_hit_score", p1_score, 2);
        checkOutput("second_hit_unfrozen", freeze, 0);

        $display("[TB] touching edges");
        p1_hit_active = 1'b0;
        applyStimulus(1);
        p1_hit_x1 = 130; p1_hit_x2 = 160;
        p1_hit_active = 1'b1;
        applyStimulus(2);
        checkOutput("edge_score", p1_score, 2);
        checkOutput("edge_freeze", freeze, 0);
        p1_hit_x1 = 150; p1_hit_x2 = 180;

        $display("[TB] third hit ends the round");
        reopenP1();
        expectHit(1'b0, 1'b1, 3, 0);
        applyStimulus(9);
        checkOutput("round_over", round_over, 1);
        checkOutput("round_winner", winner, 1);
        checkOutput("round_freeze", freeze, 1);
        applyStimulus(2);
        checkOutput("round_held", round_over, 1);
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        checkOutput("restart_score", {p1_score, p2_score}, 0);
        checkOutput("restart_round_over", round_over, 0);
        checkOutput("restart_winner", winner, 0);
        checkOutput("restart_freeze", freeze, 0);

        $display("[TB] simultaneous strikes");
        p1_hit_active = 1'b0;
        applyStimulus(1);
        p1_hit_active = 1'b1;
        p2_hit_active = 1'b1;
`ifdef TRADE_EN
        expectHit(1'b1, 1'b1, 1, 1);
        applyStimulus(1);
        checkOutput("trade_freeze", freeze, 1);
        applyStimulus(8);
        checkOutput("trade_scores", {p1_score, p2_score}, 8'h11);
        checkOutput("trade_unfrozen", freeze, 0);
`else
        applyStimulus(1);
        checkOutput("clash_freeze", freeze, 0);
        checkOutput("clash_scores", {p1_score, p2_score}, 0);
        applyStimulus(2);
        checkOutput("clash_no_retrigger", {p1_score, p2_score}, 0);
`endif

        $display("[TB] reset during hitstop");
        p1_hit_active = 1'b0;
        p2_hit_active = 1'b0;
        applyStimulus(1);
        p1_hit_active = 1'b1;
`ifdef TRADE_EN
        expectHit(1'b0, 1'b1, 2, 1);
`else
        expectHit(1'b0, 1'b1, 1, 0);
`endif
        applyStimulus(1);
        applyStimulus(4);
        checkOutput("mid_hitstop_freeze", freeze, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_freeze", freeze, 0);
        checkOutput("rst_scores", {p1_score, p2_score}, 0);
        checkOutput("rst_round_over", round_over, 0);
        expectHit(1'b0, 1'b1, 1, 0);
        applyStimulus(1);
        checkOutput("post_rst_hit_freeze", freeze, 1);

        repeat (4) @(posedge clk);
        checkOutput("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hit_arbiter.md
Name: hit_arbiter

Overview:
Downstream consumer of both players' Sprite_Hitbox outputs. Once per frame it tests each player's hitbox against the opponent's hurtbox and registers at most one hit per attack-active window. It arbitrates simultaneous hits, runs a hitstop freeze, and keeps the round score. It drives the hit/freeze/round-over controls back to the two player FSMs and the renderer.

Parameters:
COORD_W, 10, width of all box coordinates (matches sprite coordinate width)
HITSTOP_FRAMES, 8, frames the game is frozen after a registered hit (1..255)
WIN_SCORE, 3, points needed to end the round (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at frame rate (VGA vsync edge); all evaluation happens on it
restart  in  1  level; leaves ROUND_OVER
p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2  in  COORD_W each  P1 hitbox
p1_hit_active  in  1  P1 hitbox valid
p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2  in  COORD_W each  P1 hurtbox
p1_hurt_active  in  1  P1 hurtbox valid
p2_* (same 10 inputs as P1)  in  as above  P2 boxes
p1_got_hit  out  1  one-cycle pulse: P1 was struck
p2_got_hit  out  1  one-cycle pulse: P2 was struck
freeze  out  1  high during HITSTOP and ROUND_OVER; player FSMs hold state
p1_score, p2_score  out  4 each  current points
round_over  out  1  high in ROUND_OVER
winner  out  2  0 none, 1 P1, 2 P2, 3 draw

Behaviour:
- Reset: state FIGHT; all outputs 0; consumed flags cleared; hitstop counter 0.
- Overlap uses half-open intervals: A hits B iff A.x1 < B.x2 && B.x1 < A.x2 && A.y1 < B.y2 && B.y1 < A.y2. Compares are unsigned COORD_W; touching edges do not overlap.
- p1_strike = p1_hit_active & p2_hurt_active & overlap(P1 hit, P2 hurt) & ~p1_consumed. p2_strike is symmetric.
- Consumed flags: pN_consumed is set when P N's strike is registered. It clears on any frame_tick where pN_hit_active = 0. This gives one hit per active window even if overlap persists.
- States:
  FIGHT: on frame_tick, evaluate strikes.
    Exactly one strike: pulse the victim's got_hit, increment the attacker's score, set that attacker's consumed flag, load hitstop = HITSTOP_FRAMES, go to HITSTOP.
    Both strikes: clash (see Optional Feature).
    No strike: stay.
  HITSTOP: freeze = 1. Decrement on each frame_tick. At 0, go to ROUND_OVER if any score >= WIN_SCORE, else go to FIGHT. Strikes are not evaluated in this state.
  ROUND_OVER: freeze = 1, round_over = 1, winner held. On restart = 1, clear scores, winner, flags and counter, then go to FIGHT the next cycle.
- Latency: strike decision uses inputs sampled in the frame_tick cycle. got_hit pulses, score and state update on the next clock edge; the pulse is exactly 1 cycle wide.
- winner is set on the HITSTOP->ROUND_OVER transition: P1 if only p1_score >= WIN_SCORE, P2 if only p2_score >= WIN_SCORE, draw if both.
- Score saturates at 15.
- frame_tick absent: nothing changes except pulse deassertion.
- rst mid-hitstop or mid-round: immediate return to reset values on the next edge.

Optional Feature:
Macro TRADE_EN.
- Defined: simultaneous strikes are a trade. Both got_hit pulse together, both scores increment, both consumed flags set, go to HITSTOP.
- Undefined: simultaneous strikes are a clash. No pulses and no score change. Both consumed flags set so the clash cannot re-trigger in the same window. Stay in FIGHT.

Decomposition:
- Package footsies_pkg:
  - arbiter state encoding (FIGHT = 0, HITSTOP = 1, ROUND_OVER = 2)
  - winner codes
  - sprite state encodings shared with the player FSM and Sprite_Hitbox (IDLE..ATTACK_RECOVERY = 0..5)
  - sprite/hitbox dimension constants (64, 128, 10, 30, 60)
- Sub-module box_overlap: combinational, parameter COORD_W. Takes two boxes and outputs overlap. Instantiated twice.

Test Plan:
- P1 hit box (150,174)-(180,234) active; P2 hurt (160..214, 110..238) active; frame_tick -> p2_got_hit 1 cycle, p1_score=1, freeze high for 8 frame_ticks, then FIGHT.
- Overlap held across 3 active windows' frames without dropping p1_hit_active -> exactly one hit. Drop p1_hit_active for one tick, reassert -> second hit, p1_score=2.
- Edge touch: P1 hit x2=160, P2 hurt x1=160 -> no hit.
- Both strike on same tick -> TRADE_EN: both pulse, scores 1/1. No TRADE_EN: no pulse, scores 0/0, state FIGHT.
- P1 scores 3 hits -> after the third hitstop, round_over=1, winner=1. restart -> scores 0, FIGHT.
- rst asserted during HITSTOP (counter=4) -> next edge: state FIGHT, freeze 0, scores 0.
